// File: rtl/accum_warp_looper_arbiter.sv
// Round-robin arbiter feeding N_SRC block commands into one registered slot for the AccumWarpLooper index stage.
// Latency: 1 cycle src_ack -> dst_rdy; the slot reloads in the dst_ack cycle with no bubble.
// Backpressure: no grant while the slot is full and unacked, or (ACCUM_ARB_CREDIT_EN) while out of block credits.
module accum_warp_looper_arbiter #(
    parameter int N_SRC        = 4,
    parameter int CMD_BW       = 128,
    parameter int MAX_INFLIGHT = 2,
    localparam int SID_BW      = $clog2(N_SRC),
    localparam int CR_BW       = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_SRC-1:0]        src_rdy,
    output logic [N_SRC-1:0]        src_ack,
    input  logic [N_SRC*CMD_BW-1:0] i_cmd,
    output logic                    dst_rdy,
    input  logic                    dst_ack,
    output logic [CMD_BW-1:0]       o_cmd,
    output logic [SID_BW-1:0]       o_srcid,
    input  logic                    i_done,
    output logic [CR_BW-1:0]        o_inflight
);

    logic [SID_BW-1:0] rr_ptr;
    logic [SID_BW-1:0] win_id;
    logic [SID_BW-1:0] nxt_ptr;
    logic [SID_BW:0]   scan;
    logic              found;
    logic              slot_free;
    logic              credit_ok;
    logic              grant;
    logic [CMD_BW-1:0] win_cmd;

    // Cyclic scan starting at the pointer; the first requester seen wins.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        scan   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            scan = {1'b0, rr_ptr} + (SID_BW+1)'(i);
            if (scan >= (SID_BW+1)'(N_SRC)) begin
                scan = scan - (SID_BW+1)'(N_SRC);
            end
            if (!found && src_rdy[scan[SID_BW-1:0]]) begin
                found  = 1'b1;
                win_id = scan[SID_BW-1:0];
            end
        end
    end

    always_comb begin
        win_cmd = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (win_id == SID_BW'(k)) begin
                win_cmd = i_cmd[k*CMD_BW +: CMD_BW];
            end
        end
    end

    assign slot_free = !dst_rdy || dst_ack;
    // Held in reset, the arbiter must not hand out acks it will then forget.
    assign grant     = found && slot_free && credit_ok && i_rst;
    assign nxt_ptr   = (win_id == SID_BW'(N_SRC - 1)) ? '0 : win_id + SID_BW'(1);

    always_comb begin
        src_ack = '0;
        for (int k = 0; k < N_SRC; k++) begin
            src_ack[k] = grant && (win_id == SID_BW'(k));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            dst_rdy <= 1'b0;
            o_cmd   <= '0;
            o_srcid <= '0;
            rr_ptr  <= '0;
        end else if (grant) begin
            dst_rdy <= 1'b1;
            o_cmd   <= win_cmd;
            o_srcid <= win_id;
            rr_ptr  <= nxt_ptr;
        end else if (dst_ack) begin
            dst_rdy <= 1'b0;
        end
    end

`ifdef ACCUM_ARB_CREDIT_EN
    logic [CR_BW-1:0] inflight_q;
    logic             done_vld;

    // A done with nothing outstanding is stray and must not underflow the count.
    assign done_vld   = i_done && (inflight_q != '0);
    assign credit_ok  = (inflight_q < CR_BW'(MAX_INFLIGHT)) || i_done;
    assign o_inflight = inflight_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            inflight_q <= '0;
        end else if (grant && !done_vld) begin
            inflight_q <= inflight_q + CR_BW'(1);
        end else if (!grant && done_vld) begin
            inflight_q <= inflight_q - CR_BW'(1);
        end
    end
`else
    logic unused_done;

    assign unused_done = i_done;
    assign credit_ok   = 1'b1;
    assign o_inflight  = '0;
`endif

endmodule

// File: tb/tb_accum_warp_looper_arbiter.sv
// Bench for accum_warp_looper_arbiter: directed scenarios plus randomized traffic against a queue-free behavioural model.
module tb_accum_warp_looper_arbiter;
    localparam int N    = 4;
    localparam int BW   = 128;
    localparam int MAXI = 2;
`ifdef ACCUM_ARB_CREDIT_EN
    localparam bit CREDIT = 1'b1;
`else
    localparam bit CREDIT = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      src_rdy;
    logic [N-1:0]      src_ack;
    logic [N*BW-1:0]   i_cmd;
    logic              dst_rdy;
    logic              dst_ack;
    logic [BW-1:0]     o_cmd;
    logic [1:0]        o_srcid;
    logic              i_done;
    logic [1:0]        o_inflight;

    accum_warp_looper_arbiter #(.N_SRC(N), .CMD_BW(BW), .MAX_INFLIGHT(MAXI)) dut (
        .i_clk(clk), .i_rst(rst_n), .src_rdy(src_rdy), .src_ack(src_ack), .i_cmd(i_cmd),
        .dst_rdy(dst_rdy), .dst_ack(dst_ack), .o_cmd(o_cmd), .o_srcid(o_srcid),
        .i_done(i_done), .o_inflight(o_inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cmds();
        for (int k = 0; k < N; k++)
            for (int w = 0; w < BW / 32; w++)
                i_cmd[k*BW + w*32 +: 32] = $urandom;
    endtask

    // Behavioural model: who the pointer favours, what the slot holds, how many blocks are outstanding.
    int            m_ptr;
    bit            m_vld;
    logic [BW-1:0] m_cmd;
    int            m_id;
    int            m_infl;
    int            m_win;
    bit            m_gnt;
    logic [N-1:0]  m_ack;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_ptr = 0; m_vld = 0; m_cmd = '0; m_id = 0; m_infl = 0;
            chk("rst_src_ack", 128'(src_ack), 128'(0));
            chk("rst_dst_rdy", 128'(dst_rdy), 128'(0));
            chk("rst_o_cmd", o_cmd, 128'(0));
            chk("rst_o_srcid", 128'(o_srcid), 128'(0));
            chk("rst_inflight", 128'(o_inflight), 128'(0));
        end else begin
            m_win = -1;
            for (int i = 0; i < N; i++) begin
                if (m_win < 0 && src_rdy[(m_ptr + i) % N]) m_win = (m_ptr + i) % N;
            end
            m_gnt = (m_win >= 0) && (!m_vld || dst_ack) &&
                    (!CREDIT || m_infl < MAXI || i_done);
            m_ack = m_gnt ? N'(1 << m_win) : '0;
            chk("src_ack", 128'(src_ack), 128'(m_ack));
            chk("dst_rdy", 128'(dst_rdy), 128'(m_vld));
            if (m_vld) begin
                chk("o_cmd", o_cmd, m_cmd);
                chk("o_srcid", 128'(o_srcid), 128'(m_id));
            end
            chk("inflight", 128'(o_inflight), 128'(CREDIT ? m_infl : 0));
            if (CREDIT) m_infl = m_infl + (m_gnt ? 1 : 0) - ((i_done && m_infl > 0) ? 1 : 0);
            if (m_gnt) begin
                m_vld = 1;
                m_cmd = i_cmd[m_win*BW +: BW];
                m_id  = m_win;
                m_ptr = (m_win + 1) % N;
            end else if (dst_ack) begin
                m_vld = 0;
            end
        end
    end

    logic [N-1:0]  seq_ack [5];
    int            seq_id  [5];
    logic [BW-1:0] saved;
    int            ngrant;

    initial begin
        seq_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq_id  = '{0, 1, 2, 3, 0};
        rst_n = 1'b0; src_rdy = '0; dst_ack = 1'b0; i_done = 1'b0;
        rand_cmds();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t1_src_ack", 128'(src_ack), 128'(0));
            chk("t1_dst_rdy", 128'(dst_rdy), 128'(0));
            chk("t1_inflight", 128'(o_inflight), 128'(0));
            tick();
        end

        // All requesting, slot always drained: strict rotation, one grant per cycle.
        src_rdy = 4'hF; dst_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i >= 1) i_done = 1'b1;
            rand_cmds();
            @(negedge clk);
            if (i < 5) chk("t2_rotation", 128'(src_ack), 128'(seq_ack[i]));
            if (i >= 1) chk("t2_srcid", 128'(o_srcid), 128'(seq_id[i-1]));
            tick();
        end
        src_rdy = '0; i_done = 1'b1;
        @(negedge clk); tick();

        // Single requester with a stalled slot: contents must hold.
        src_rdy = 4'b0100; dst_ack = 1'b0; i_done = 1'b0;
        @(negedge clk);
        chk("t3_grant2", 128'(src_ack), 128'(4'b0100));
        saved = i_cmd[2*BW +: BW];
        tick();
        for (int i = 0; i < 10; i++) begin
            rand_cmds();
            @(negedge clk);
            chk("t3_hold_rdy", 128'(dst_rdy), 128'(1));
            chk("t3_hold_cmd", o_cmd, saved);
            chk("t3_hold_id", 128'(o_srcid), 128'(2));
            chk("t3_no_ack", 128'(src_ack), 128'(0));
            tick();
        end
        dst_ack = 1'b1;
        @(negedge clk);
        chk("t3_regrant", 128'(src_ack), 128'(4'b0100));
        tick();
        src_rdy = '0; i_done = 1'b1;
        repeat (2) begin @(negedge clk); tick(); end
        i_done = 1'b0;

`ifdef ACCUM_ARB_CREDIT_EN
        // Credit exhaustion, then a done frees a credit in the same cycle.
        src_rdy = 4'hF; dst_ack = 1'b1; ngrant = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (src_ack != '0) ngrant++;
            tick();
        end
        chk("t4_grant_count", 128'(ngrant), 128'(2));
        @(negedge clk);
        chk("t4_starved", 128'(src_ack), 128'(0));
        chk("t4_full", 128'(o_inflight), 128'(2));
        tick();
        i_done = 1'b1;
        @(negedge clk);
        chk("t4_done_grant", 128'(src_ack), 128'(4'b0010));
        tick();
        i_done = 1'b0;
        @(negedge clk);
        chk("t4_still_full", 128'(o_inflight), 128'(2));
        chk("t4_starved2", 128'(src_ack), 128'(0));
        tick();

        // Drain to zero, then a stray done must not underflow.
        src_rdy = '0; i_done = 1'b1;
        repeat (3) begin @(negedge clk); tick(); end
        i_done = 1'b0; src_rdy = 4'b0001;
        @(negedge clk);
        chk("t5_no_underflow", 128'(o_inflight), 128'(0));
        chk("t5_grant0", 128'(src_ack), 128'(4'b0001));
        tick();
        src_rdy = '0;
        @(negedge clk);
        chk("t5_one", 128'(o_inflight), 128'(1));
        tick();
`endif

        // Asynchronous reset with a loaded slot.
        src_rdy = 4'hF; dst_ack = 1'b1; i_done = 1'b0;
        @(negedge clk); tick();
        dst_ack = 1'b0;
        #2;
        chk("t6_pre_rdy", 128'(dst_rdy), 128'(1));
        chk("t6_pre_infl", 128'(o_inflight), 128'(CREDIT ? 2 : 0));
        rst_n = 1'b0;
        #1;
        chk("t6_async_rdy", 128'(dst_rdy), 128'(0));
        chk("t6_async_infl", 128'(o_inflight), 128'(0));
        chk("t6_async_ack", 128'(src_ack), 128'(0));
        repeat (2) tick();
        rst_n = 1'b1; dst_ack = 1'b1;
        @(negedge clk);
        chk("t6_ptr_zero", 128'(src_ack), 128'(4'b0001));
        tick();

        // Randomized traffic, model-checked every cycle.
        for (int c = 0; c < 3000; c++) begin
            src_rdy = ($urandom % 4 == 0) ? N'(0) : N'($urandom_range(0, 15));
            dst_ack = ($urandom % 4) != 0;
            i_done  = ($urandom % 3) == 0;
            rand_cmds();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
